// File: rtl/datapath_sequencer_if.sv
// Decoder/serial-side handshake bundle for the datapath sequencer.
// master = instruction decode + serial port side, slave = sequencer.
interface datapath_sequencer_if;
  logic       re_req_in;
  logic       we_req_in;
  logic       regfile_we_req_in;
  logic       serial_sel_in;
  logic       halt_in;
  logic       serial_valid_in;
  logic       serial_ready_in;
  logic       pc_en_out;
  logic       regfile_we_out;
  logic       data_mem_re_out;
  logic       data_mem_we_out;
  logic       serial_timeout_out;
  logic [1:0] state_out;

  modport master (
    output re_req_in, we_req_in, regfile_we_req_in, serial_sel_in, halt_in,
           serial_valid_in, serial_ready_in,
    input  pc_en_out, regfile_we_out, data_mem_re_out, data_mem_we_out,
           serial_timeout_out, state_out
  );

  modport slave (
    input  re_req_in, we_req_in, regfile_we_req_in, serial_sel_in, halt_in,
           serial_valid_in, serial_ready_in,
    output pc_en_out, regfile_we_out, data_mem_re_out, data_mem_we_out,
           serial_timeout_out, state_out
  );
endinterface

// File: rtl/datapath_sequencer.sv
// Stalls/retires instructions around multi-cycle data-memory loads and
// serial-port accesses; gates PC advance, register write and memory enables.
module datapath_sequencer #(
  parameter int MEM_LATENCY = 1,
  parameter int SER_TIMEOUT = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  datapath_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    SER_WAIT = 2'd2,
    HALTED   = 2'd3
  } state_t;

  localparam logic [3:0] LAT      = 4'(MEM_LATENCY);
  localparam logic [7:0] TMO_LAST = 8'(SER_TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [7:0] tmr, tmr_nxt;
  logic       tmo, tmo_nxt;
  logic       pc_en, rf_we, mem_re, mem_we;
  logic       rd, wr, ser_acc, ser_ok;

  // A simultaneous read+write request is a write; the read is dropped.
  assign rd      = bus.re_req_in & ~bus.we_req_in;
  assign wr      = bus.we_req_in;
  assign ser_acc = bus.serial_sel_in & (rd | wr);
  assign ser_ok  = wr ? bus.serial_ready_in : bus.serial_valid_in;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
      cnt   <= 4'd0;
      tmr   <= 8'd0;
      tmo   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      tmr   <= tmr_nxt;
      tmo   <= tmo_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tmr_nxt   = tmr;
    tmo_nxt   = tmo;
    pc_en     = 1'b0;
    rf_we     = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    case (state)
      RUN: begin
        if (bus.halt_in) begin
          state_nxt = HALTED;
        end else if (ser_acc && !ser_ok) begin
          tmr_nxt   = 8'd0;
          state_nxt = SER_WAIT;
        end else if (rd && !bus.serial_sel_in && (LAT != 4'd0)) begin
          mem_re    = 1'b1;
          cnt_nxt   = LAT;
          state_nxt = MEM_WAIT;
        end else begin
          pc_en  = 1'b1;
          rf_we  = bus.regfile_we_req_in;
          mem_re = rd;
          mem_we = wr;
        end
      end
      MEM_WAIT: begin
        mem_re = 1'b1;
        if (cnt <= 4'd1) begin
          pc_en     = 1'b1;
          rf_we     = bus.regfile_we_req_in;
          cnt_nxt   = 4'd0;
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      SER_WAIT: begin
        // A late handshake wins over a coincident timeout.
        if (ser_ok) begin
          pc_en     = 1'b1;
          rf_we     = bus.regfile_we_req_in;
          mem_re    = rd;
          mem_we    = wr;
          state_nxt = RUN;
        end else if (tmr == TMO_LAST) begin
          tmo_nxt   = 1'b1;
          pc_en     = 1'b1;
          state_nxt = RUN;
        end else if (tmr != 8'hFF) begin
          tmr_nxt = tmr + 8'd1;
        end
      end
      default: ;
    endcase
  end

  // Reset masks every output in the same cycle it is asserted.
  assign bus.pc_en_out          = pc_en  & ~reset;
  assign bus.regfile_we_out     = rf_we  & ~reset;
  assign bus.data_mem_re_out    = mem_re & ~reset;
  assign bus.data_mem_we_out    = mem_we & ~reset;
  assign bus.serial_timeout_out = tmo    & ~reset;
  assign bus.state_out          = reset ? 2'd0 : state;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer; output vector is
// {pc_en, regfile_we, mem_re, mem_we, timeout, state[1:0]}.
module tb_datapath_sequencer;
  logic clock = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  datapath_sequencer_if bus ();
  datapath_sequencer_if bus0 ();

  datapath_sequencer #(.MEM_LATENCY(2), .SER_TIMEOUT(8)) u_dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  datapath_sequencer #(.MEM_LATENCY(0), .SER_TIMEOUT(255)) u_dut0 (
    .clock(clock), .reset(reset), .bus(bus0)
  );

  logic [6:0] outs, outs0;
  assign outs  = {bus.pc_en_out, bus.regfile_we_out, bus.data_mem_re_out,
                  bus.data_mem_we_out, bus.serial_timeout_out, bus.state_out};
  assign outs0 = {bus0.pc_en_out, bus0.regfile_we_out, bus0.data_mem_re_out,
                  bus0.data_mem_we_out, bus0.serial_timeout_out, bus0.state_out};

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic re, input logic we, input logic rf, input logic sel,
                       input logic halt, input logic valid, input logic ready);
    bus.re_req_in  = re;    bus0.re_req_in  = re;
    bus.we_req_in  = we;    bus0.we_req_in  = we;
    bus.regfile_we_req_in = rf; bus0.regfile_we_req_in = rf;
    bus.serial_sel_in = sel; bus0.serial_sel_in = sel;
    bus.halt_in    = halt;  bus0.halt_in    = halt;
    bus.serial_valid_in = valid; bus0.serial_valid_in = valid;
    bus.serial_ready_in = ready; bus0.serial_ready_in = ready;
    #1;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // reset forces outputs low even with requests present
    reset = 1'b1;
    drive(1, 0, 1, 0, 0, 0, 0);
    chk("rst_force", outs, 7'b0000000);
    step(); step();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("run_first", outs, 7'b1000000);
    step();

    drive(0, 0, 1, 0, 0, 0, 0);
    chk("alu_rf", outs, 7'b1100000);
    step();
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("mem_write", outs, 7'b1001000);
    step();
    drive(1, 1, 0, 0, 0, 0, 0);
    chk("rw_is_write", outs, 7'b1001000);
    step();

    // load, MEM_LATENCY=2: pc 0,0,1 and rf only in 3rd cycle
    drive(1, 0, 1, 0, 0, 0, 0);
    chk("load_c1", outs, 7'b0010000);
    chk("load_lat0", outs0, 7'b1110000);
    step();
    chk("load_c2", outs, 7'b0010001);
    step();
    chk("load_c3", outs, 7'b1110001);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("load_done", outs, 7'b1000000);
    step();

    // serial read, valid arrives after 4 wait cycles
    drive(1, 0, 1, 1, 0, 0, 0);
    chk("ser_rd_run", outs, 7'b0000000);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("ser_rd_wait", outs, 7'b0000010);
      step();
    end
    drive(1, 0, 1, 1, 0, 1, 0);
    chk("ser_rd_done", outs, 7'b1110010);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("ser_rd_back", outs, 7'b1000000);
    step();

    drive(0, 1, 0, 1, 0, 0, 1);
    chk("ser_wr_ready", outs, 7'b1001000);
    step();

    // halt, then hold through arbitrary inputs
    drive(0, 0, 1, 0, 1, 0, 0);
    chk("halt_enter", outs, 7'b0000000);
    step();
    for (int i = 0; i < 20; i++) begin
      drive(i[0], ~i[0], 1'b1, i[1], 1'b0, 1'b1, 1'b1);
      chk("halt_hold", outs, 7'b0000011);
      step();
    end
    reset = 1'b1;
    #1;
    chk("halt_rst", outs, 7'b0000000);
    step();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("halt_cleared", outs, 7'b1000000);
    step();

    // serial write timeout, SER_TIMEOUT=8
    drive(0, 1, 1, 1, 0, 0, 0);
    chk("tmo_run", outs, 7'b0000000);
    step();
    for (int i = 0; i < 7; i++) begin
      chk("tmo_wait", outs, 7'b0000010);
      step();
    end
    chk("tmo_retire", outs, 7'b1000010);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("tmo_flag", outs, 7'b1000100);
    step();
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("tmo_sticky", outs, 7'b1001100);
    step();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b0;
    #1;
    chk("tmo_cleared", outs, 7'b1000000);
    step();

    // ready arrives exactly on the timeout cycle: normal completion
    drive(0, 1, 1, 1, 0, 0, 0);
    step();
    for (int i = 0; i < 7; i++) begin
      chk("tie_wait", outs, 7'b0000010);
      step();
    end
    drive(0, 1, 1, 1, 0, 0, 1);
    chk("tie_done", outs, 7'b1101010);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("tie_noflag", outs, 7'b1000000);
    step();

    // reset in 2nd MEM_WAIT cycle aborts the load
    drive(1, 0, 1, 0, 0, 0, 0);
    chk("abort_c1", outs, 7'b0010000);
    step();
    chk("abort_c2", outs, 7'b0010001);
    step();
    reset = 1'b1;
    #1;
    chk("abort_rst", outs, 7'b0000000);
    step();
    reset = 1'b0;
    #1;
    chk("abort_rerun", outs, 7'b0010000);
    step();
    chk("abort_wait", outs, 7'b0010001);
    step();
    chk("abort_retire", outs, 7'b1110001);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("final_idle", outs, 7'b1000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/datapath_sequencer.md
DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 1, meaning extra wait cycles for a non-serial data memory load (range 0..15).
REQ-002 SHALL have parameter SER_TIMEOUT, default 255, meaning the maximum number of stall cycles on a serial access before it is abandoned (range 1..255).
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port re_req_in, input, 1 bit: the decoded instruction requests a data memory read.
REQ-006 SHALL have port we_req_in, input, 1 bit: the decoded instruction requests a data memory write.
REQ-007 SHALL have port regfile_we_req_in, input, 1 bit: the decoded instruction requests a register write.
REQ-008 SHALL have port serial_sel_in, input, 1 bit: the current access targets the serial address.
REQ-009 SHALL have port halt_in, input, 1 bit: the decoded instruction is a halt/break.
REQ-010 SHALL have port serial_valid_in, input, 1 bit: a receive byte is available.
REQ-011 SHALL have port serial_ready_in, input, 1 bit: the transmitter can accept a byte.
REQ-012 SHALL have port pc_en_out, output, 1 bit: PC advance enable.
REQ-013 SHALL have port regfile_we_out, output, 1 bit: gated register-file write enable.
REQ-014 SHALL have port data_mem_re_out, output, 1 bit: gated data memory read enable.
REQ-015 SHALL have port data_mem_we_out, output, 1 bit: gated data memory write enable.
REQ-016 SHALL have port serial_timeout_out, output, 1 bit: sticky serial-timeout flag.
REQ-017 SHALL have port state_out, output, 2 bits: current state (RUN=0, MEM_WAIT=1, SER_WAIT=2, HALTED=3).

Function
REQ-018 Outputs SHALL be combinational from state, counters and inputs; the environment holds the *_req_in, serial_sel_in and halt_in inputs stable while pc_en_out=0.
REQ-019 When re_req_in=1 and we_req_in=1 together, SHALL treat the access as a write; the read is suppressed.
REQ-020 In RUN with halt_in=1, SHALL drive all enables 0 and go to HALTED.
REQ-021 In RUN with a non-serial read and MEM_LATENCY>0, SHALL drive data_mem_re_out=1, pc_en_out=0, regfile_we_out=0, load the wait counter with MEM_LATENCY, and go to MEM_WAIT.
REQ-022 In MEM_WAIT, SHALL drive data_mem_re_out=1 and decrement the counter each cycle.
REQ-023 In MEM_WAIT with counter=1, SHALL drive pc_en_out=1 and regfile_we_out=regfile_we_req_in, then return to RUN; a load therefore retires in 1+MEM_LATENCY cycles.
REQ-024 In RUN with a serial read and serial_valid_in=0, or a serial write and serial_ready_in=0, SHALL drive all enables 0, clear the timer to 0, and go to SER_WAIT.
REQ-025 In SER_WAIT, SHALL increment the timer each cycle while keeping the enables at 0.
REQ-026 When the awaited serial condition goes true in SER_WAIT, in that same cycle SHALL drive data_mem_re_out or data_mem_we_out=1, pc_en_out=1 and regfile_we_out=regfile_we_req_in, then go to RUN.
REQ-027 In SER_WAIT, if the timer equals SER_TIMEOUT-1 and the condition is still false, SHALL set serial_timeout_out, retire the instruction with pc_en_out=1 and regfile_we_out=0, drive both memory enables 0, and go to RUN.
REQ-028 If the condition goes true in the same cycle as the timeout, SHALL complete the access normally and SHALL NOT set the flag.
REQ-029 All other cases in RUN (ALU, branch, jump, ready serial access, non-serial write, read with MEM_LATENCY=0) SHALL complete in one cycle: pc_en_out=1 and each gated enable equal to its request.
REQ-030 HALTED SHALL hold all enables at 0 until reset, ignoring all inputs.
REQ-031 The timer SHALL saturate and never wrap, and the counter SHALL NOT underflow.

Reset
REQ-032 While reset=1, SHALL force every output to 0; at the next edge, state=RUN, counter=0, timer=0, serial_timeout_out=0.
REQ-033 Reset asserted mid-MEM_WAIT or mid-SER_WAIT SHALL abort the access with no enable pulse, and SHALL clear HALTED.
REQ-034 The first cycle after reset deasserts SHALL evaluate as RUN.

Verification
REQ-035 Scenario: MEM_LATENCY=2, non-serial load with regfile_we_req_in=1 -> pc_en_out pattern 0,0,1; data_mem_re_out=1 for 3 cycles; regfile_we_out=1 only in the 3rd cycle.
REQ-036 Scenario: serial read with serial_valid_in rising after 4 cycles -> state_out=2 for 4 cycles, then a single cycle with data_mem_re_out=1 and pc_en_out=1.
REQ-037 Scenario: SER_TIMEOUT=8, serial write with serial_ready_in held 0 -> serial_timeout_out=1 after 8 stall cycles, data_mem_we_out never 1, pc_en_out=1 once, flag held until reset.
REQ-038 Scenario: re_req_in=1 and we_req_in=1, non-serial -> one-cycle retire with data_mem_we_out=1 and data_mem_re_out=0.
REQ-039 Scenario: halt_in=1 -> state_out=3 and pc_en_out=0 for 20+ cycles, then reset -> state_out=0.
REQ-040 Scenario: reset asserted in the 2nd cycle of MEM_WAIT -> outputs 0 that cycle, state_out=0 after, and no regfile_we_out pulse.
